// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//    Packs a stream of decoded ARM instruction fields into 32-bit instruction
//    words and writes them to consecutive instruction-memory words, starting
//    at a programmed base address and wrapping modulo 2^ADDR_W.
//
// Ports
//    clk, reset_n          clock, asynchronous active-low reset
//    start                 begin a load (honoured only in IDLE or ERROR)
//    base_addr, count      first word address / number of beats, latched on start
//    in_valid, in_ready    field beat handshake
//    cond, op, funct,      decoded instruction fields; op=11 is illegal and
//    rn, rd, src2, imm24   aborts the load into ERROR
//    imem_we, imem_addr,   registered instruction-memory write port
//    imem_wdata
//    busy                  high in LOAD and DONE
//    done                  one-cycle completion pulse
//    err                   illegal op seen, held until the next start
module instr_encoder_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        cond,
   input  logic [1:0]        op,
   input  logic [5:0]        funct,
   input  logic [3:0]        rn,
   input  logic [3:0]        rd,
   input  logic [11:0]       src2,
   input  logic [23:0]       imm24,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W:0]   remaining;
   logic              accept;
   logic              start_ok;
   logic              illegal;

   // Branch words carry only the top two funct bits (link/cond-class) ahead
   // of the 24-bit offset; everything else uses the full field layout.
   function automatic logic [31:0] encode_word(
      input logic [3:0]  c,
      input logic [1:0]  o,
      input logic [5:0]  f,
      input logic [3:0]  n,
      input logic [3:0]  d,
      input logic [11:0] s,
      input logic [23:0] i24
   );
      if (o == 2'b10)
         return {c, o, f[5:4], i24};
      else
         return {c, o, f, n, d, s};
   endfunction

   // in_ready depends only on registered state so the handshake never forms
   // a combinational path from in_valid back to in_ready.
   assign in_ready = (state == LOAD) && (remaining != '0);
   assign accept   = in_valid & in_ready;
   assign start_ok = start && ((state == IDLE) || (state == ERROR));
   assign illegal  = (op == 2'b11);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = (count != '0) ? LOAD : DONE;
         end
         LOAD: begin
            busy = 1'b1;
            if (accept) begin
               if (illegal)
                  state_nxt = ERROR;
               else if (remaining == {{ADDR_W{1'b0}}, 1'b1})
                  state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         ERROR: begin
            err = 1'b1;
            if (start)
               state_nxt = (count != '0) ? LOAD : DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Write stage: an accepted legal beat is registered onto the memory port
   // for exactly one cycle; the pointer advances only for words written.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr       <= '0;
         remaining  <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (start_ok) begin
            wptr      <= base_addr;
            remaining <= count;
         end else if (accept) begin
            remaining <= remaining - 1'b1;
            if (!illegal) begin
               imem_we    <= 1'b1;
               imem_addr  <= wptr;
               imem_wdata <= encode_word(cond, op, funct, rn, rd, src2, imm24);
               wptr       <= wptr + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      logic [3:0]  cond;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [11:0] src2;
      logic [23:0] imm24;
   } beat_t;

   typedef struct {
      logic [5:0]  base;
      beat_t       b;
      logic [5:0]  ea;
      logic [31:0] ed;
   } vec_t;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   count = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        cond = '0;
   logic [1:0]        op = '0;
   logic [5:0]        funct = '0;
   logic [3:0]        rn = '0;
   logic [3:0]        rd = '0;
   logic [11:0]       src2 = '0;
   logic [23:0]       imm24 = '0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              busy;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   wr_t exp_q[$];
   int  wr_cyc[$];

   instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .count(count), .in_valid(in_valid), .in_ready(in_ready), .cond(cond),
      .op(op), .funct(funct), .rn(rn), .rd(rd), .src2(src2), .imm24(imm24),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Every write seen on the memory port must match the next expected write.
   always @(negedge clk) begin
      if (reset_n && imem_we) begin
         wr_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("write_addr", 32'(imem_addr), 32'(w.addr));
            check("write_data", imem_wdata, w.data);
         end
      end
   end

   // Reference encoding from field positions using plain arithmetic.
   function automatic logic [31:0] model_word(input beat_t b);
      longint w;
      w = longint'(b.cond) * (64'd1 << 28) + longint'(b.op) * (64'd1 << 26);
      if (b.op == 2'd2)
         w = w + (longint'(b.funct) / 16) * (64'd1 << 24) + longint'(b.imm24);
      else
         w = w + longint'(b.funct) * (64'd1 << 20) + longint'(b.rn) * (64'd1 << 16)
               + longint'(b.rd) * (64'd1 << 12) + longint'(b.src2);
      return w[31:0];
   endfunction

   function automatic beat_t mk_beat(input logic [3:0] c, input logic [1:0] o,
      input logic [5:0] f, input logic [3:0] n, input logic [3:0] d,
      input logic [11:0] s, input logic [23:0] i);
      beat_t b;
      b.cond = c; b.op = o; b.funct = f; b.rn = n; b.rd = d; b.src2 = s; b.imm24 = i;
      return b;
   endfunction

   function automatic beat_t rand_beat(input logic [1:0] o);
      return mk_beat(4'($urandom), o, 6'($urandom), 4'($urandom), 4'($urandom),
                     12'($urandom), 24'($urandom));
   endfunction

   // All tasks start and end 1 time unit after a rising edge.
   task automatic start_load(input int base, input int cnt);
      start = 1'b1;
      base_addr = 6'(base);
      count = 7'(cnt);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic apply_beat(input beat_t b, input logic [5:0] ea, input logic [31:0] ed,
                             input bit legal, output int waited);
      wr_t w;
      cond = b.cond; op = b.op; funct = b.funct; rn = b.rn; rd = b.rd;
      src2 = b.src2; imm24 = b.imm24;
      in_valid = 1'b1;
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         check("beat_accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      if (legal) begin
         w.addr = ea; w.data = ed;
         exp_q.push_back(w);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic finish_load(input string tag, input bit last_wrote);
      check({tag, "_done_pulse"}, 32'(done), 32'd1);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
      check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
      check({tag, "_final_we"}, 32'(imem_we), 32'(last_wrote));
      @(posedge clk); #1;
      check({tag, "_done_cleared"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_we"}, 32'(imem_we), 32'd0);
   endtask

   initial begin
      vec_t  vecs[6];
      beat_t add_b, ldr_b, b_b, ill_b, bx;
      int    waited, n0, ptr, cnt;

      add_b = mk_beat(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0);
      ldr_b = mk_beat(4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 12'h008, 24'h0);
      b_b   = mk_beat(4'hE, 2'b10, 6'b100000, 4'd0, 4'd0, 12'h000, 24'h000002);
      ill_b = mk_beat(4'hE, 2'b11, 6'b000000, 4'd1, 4'd1, 12'h001, 24'h0);

      vecs[0] = '{base: 6'd0,  b: add_b, ea: 6'd0,  ed: 32'hE2821005};
      vecs[1] = '{base: 6'd10, b: ldr_b, ea: 6'd10, ed: 32'hE5903008};
      vecs[2] = '{base: 6'd20, b: b_b,   ea: 6'd20, ed: 32'hEA000002};
      vecs[3] = '{base: 6'd33, b: mk_beat(4'h0, 2'b00, 6'b000100, 4'hF, 4'hF, 12'hFFF, 24'h0),
                  ea: 6'd33, ed: 32'h004FFFFF};
      vecs[4] = '{base: 6'd63, b: mk_beat(4'h1, 2'b10, 6'b110101, 4'h5, 4'h6, 12'h777, 24'hABCDEF),
                  ea: 6'd63, ed: 32'h1BABCDEF};
      vecs[5] = '{base: 6'd1,  b: mk_beat(4'hA, 2'b01, 6'b111111, 4'h9, 4'hC, 12'h123, 24'h0),
                  ea: 6'd1,  ed: 32'hA7F9C123};

      // Reset state
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Table vectors: single-instruction loads
      for (int i = 0; i < 6; i++) begin
         start_load(int'(vecs[i].base), 1);
         check("vec_busy_after_start", 32'(busy), 32'd1);
         apply_beat(vecs[i].b, vecs[i].ea, vecs[i].ed, 1'b1, waited);
         finish_load("vec", 1'b1);
      end

      // Three-instruction program, back-to-back beats
      n0 = wr_cyc.size();
      start_load(5, 3);
      apply_beat(add_b, 6'd5, 32'hE2821005, 1'b1, waited);
      check("prog_beat0_wait", 32'(waited), 32'd0);
      apply_beat(ldr_b, 6'd6, 32'hE5903008, 1'b1, waited);
      check("prog_beat1_wait", 32'(waited), 32'd0);
      apply_beat(b_b, 6'd7, 32'hEA000002, 1'b1, waited);
      check("prog_beat2_wait", 32'(waited), 32'd0);
      finish_load("prog", 1'b1);
      check("prog_write_count", 32'(wr_cyc.size() - n0), 32'd3);
      if (wr_cyc.size() - n0 == 3) begin
         check("prog_consec_1", 32'(wr_cyc[n0+1] - wr_cyc[n0]), 32'd1);
         check("prog_consec_2", 32'(wr_cyc[n0+2] - wr_cyc[n0+1]), 32'd1);
      end

      // Address wrap 63 -> 0
      start_load(63, 2);
      apply_beat(add_b, 6'd63, 32'hE2821005, 1'b1, waited);
      apply_beat(ldr_b, 6'd0, 32'hE5903008, 1'b1, waited);
      finish_load("wrap", 1'b1);

      // Stall pattern 1,0,0,1
      n0 = wr_cyc.size();
      start_load(12, 2);
      apply_beat(add_b, 6'd12, 32'hE2821005, 1'b1, waited);
      repeat (2) begin
         check("stall_ready_held", 32'(in_ready), 32'd1);
         check("stall_busy", 32'(busy), 32'd1);
         @(posedge clk); #1;
      end
      apply_beat(b_b, 6'd13, 32'hEA000002, 1'b1, waited);
      finish_load("stall", 1'b1);
      check("stall_write_count", 32'(wr_cyc.size() - n0), 32'd2);

      // Illegal op mid-load
      n0 = wr_cyc.size();
      start_load(8, 3);
      apply_beat(add_b, 6'd8, 32'hE2821005, 1'b1, waited);
      apply_beat(ill_b, 6'd0, 32'd0, 1'b0, waited);
      check("ill_err_set", 32'(err), 32'd1);
      check("ill_ready_low", 32'(in_ready), 32'd0);
      check("ill_we_low", 32'(imem_we), 32'd0);
      check("ill_not_busy", 32'(busy), 32'd0);
      bx = rand_beat(2'b00);
      cond = bx.cond; op = bx.op; funct = bx.funct; in_valid = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         check("ill_no_accept", 32'(in_ready), 32'd0);
         check("ill_err_held", 32'(err), 32'd1);
      end
      in_valid = 1'b0;
      check("ill_write_count", 32'(wr_cyc.size() - n0), 32'd1);
      start_load(50, 2);
      check("ill_err_cleared", 32'(err), 32'd0);
      check("ill_restart_busy", 32'(busy), 32'd1);
      apply_beat(ldr_b, 6'd50, 32'hE5903008, 1'b1, waited);
      apply_beat(add_b, 6'd51, 32'hE2821005, 1'b1, waited);
      finish_load("restart", 1'b1);

      // count = 0
      n0 = wr_cyc.size();
      start_load(3, 0);
      finish_load("zero", 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("zero_no_writes", 32'(wr_cyc.size() - n0), 32'd0);

      // Randomized loads against the reference model
      for (int l = 0; l < 8; l++) begin
         ptr = int'($urandom_range(0, DEPTH - 1));
         cnt = int'($urandom_range(1, 9));
         start_load(ptr, cnt);
         for (int i = 0; i < cnt; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk); #1;
               check("rand_stall_ready", 32'(in_ready), 32'd1);
            end
            bx = rand_beat(2'($urandom_range(0, 2)));
            apply_beat(bx, 6'(ptr), model_word(bx), 1'b1, waited);
            ptr = (ptr + 1) % DEPTH;
         end
         finish_load("rand", 1'b1);
      end

      // Reset asserted mid-load
      start_load(40, 10);
      for (int i = 0; i < 3; i++) begin
         bx = rand_beat(2'b01);
         apply_beat(bx, 6'(40 + i), model_word(bx), 1'b1, waited);
      end
      #1 reset_n = 1'b0;
      #1;
      exp_q.delete();
      check("mid_rst_we", 32'(imem_we), 32'd0);
      check("mid_rst_addr", 32'(imem_addr), 32'd0);
      check("mid_rst_wdata", imem_wdata, 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      n0 = wr_cyc.size();
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("post_rst_idle_ready", 32'(in_ready), 32'd0);
         check("post_rst_idle_busy", 32'(busy), 32'd0);
      end
      in_valid = 1'b0;
      check("post_rst_no_writes", 32'(wr_cyc.size() - n0), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
      $fatal(1);
   end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and loader for the single-cycle ARM core. It accepts a stream of decoded instruction fields (cond, op, funct, Rn, Rd, Src2 / imm24) over a valid/ready handshake. Each beat is packed into a 32-bit ARM instruction word and written into consecutive instruction-memory words from a programmed base address. It sits between the test/boot controller and the instruction-memory write port, and produces exactly the fields the core's decoder later consumes.

## Interface
- ADDR_W, 6, instruction-memory word-address width (2^ADDR_W words)
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin a load; sampled only in IDLE or ERROR
- base_addr  input  ADDR_W  first word address, latched on start
- count  input  ADDR_W+1  number of instructions to load, latched on start
- in_valid  input  1  field beat valid
- in_ready  output  1  field beat accepted when in_valid & in_ready
- cond  input  4  condition field
- op  input  2  00 data-processing, 01 memory, 10 branch, 11 illegal
- funct  input  6  instruction bits [25:20]
- rn, rd  input  4 each  register fields (ignored for branch)
- src2  input  12  operand-2/offset field (ignored for branch)
- imm24  input  24  branch offset (used only for op=10)
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  ADDR_W  word write address
- imem_wdata  output  32  encoded instruction
- busy  output  1  high in LOAD and DONE
- done  output  1  one-cycle pulse on load completion
- err  output  1  illegal op seen; held until next start

## Operation
- States: IDLE, LOAD, DONE, ERROR.
- IDLE: start=1 latches base_addr into the write pointer and count into remaining. Next state is LOAD if count≠0, else DONE.
- LOAD: in_ready = (remaining≠0). On each accepted beat, remaining decrements.
  - op=00/01: word = {cond, op, funct, rn, rd, src2}.
  - op=10: word = {cond, op, funct[5:4], imm24}.
  - op=11: no write. Go to ERROR and set err. Words already written stay in memory.
- LOAD → DONE on the edge after the last beat is accepted, i.e. remaining reaches 0.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: in_ready=0, err=1. start=1 clears err, latches new base_addr/count, and proceeds exactly as from IDLE.
- start while in LOAD or DONE is ignored.
- Write pointer increments by 1 per written word and wraps modulo 2^ADDR_W (the word at address 2^ADDR_W−1 is followed by address 0).
- Legal count range: 0 to 2^ADDR_W. count > 2^ADDR_W overwrites wrapped addresses; no error is flagged.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, err 0, remaining 0.
- Reset mid-load aborts immediately. No further writes are issued.
- Write latency is 1 cycle. A beat accepted at edge t produces imem_we=1 with registered imem_addr/imem_wdata during cycle t+1 to t+2, committed at edge t+2.
- Throughput: one instruction per cycle when in_valid is held high.
- imem_we is asserted only for legal accepted beats and never in IDLE, DONE, or ERROR (except for the final write, which is still in flight during the first cycle of DONE).
- in_valid low in LOAD is a stall: no state change.
- Last accepted beat at edge t: DONE during t+1 to t+2, done=1 in that cycle, the final imem_we is also high in that cycle, and IDLE from t+2.
- count=0: start at edge t gives DONE during t+1 with done=1 and no writes.
- The illegal beat accepted at edge t puts the block in ERROR from t+1, with err=1 and imem_we=0.

## Test plan
- base_addr=0, count=1, beat {cond=E, op=00, funct=101000, rn=2, rd=1, src2=005} -> one write: addr 0, data 32'hE2821005; done pulses one cycle later.
- base_addr=5, count=3, continuous beats for ADD (above), then LDR {E, 01, 011001, rn=0, rd=3, src2=008}, then B {E, 10, funct=10xxxx, imm24=000002} -> writes E2821005@5, E5903008@6, EA000002@7 on three consecutive cycles.
- base_addr=63, count=2, ADDR_W=6 -> writes land at addresses 63 then 0.
- count=2 with in_valid toggling 1,0,0,1 -> exactly 2 writes with no duplicate; in_ready falls after the second beat.
- count=3 with the second beat op=11 -> first word written, err=1, in_ready=0, no third acceptance. A new start clears err and a subsequent load completes.
- count=0 start -> done pulse, no imem_we. Separately, assert reset_n low mid-LOAD -> all outputs go to 0 immediately and state returns to IDLE.
